// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: owns the PC, addresses the single-cycle ROM and
// registers the fetched word, its PC and PC+4 into the IF/ID stage.
module fetch_control #(
   parameter int          profundidad = 1024,
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter logic [31:0] NOP         = 32'h0000_0013
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_stall,
   input  logic                           i_branch_taken,
   input  logic [31:0]                    i_branch_target,
   output logic [$clog2(profundidad)-1:0] o_rom_address,
   input  logic [31:0]                    i_rom_data,
   output logic [31:0]                    o_instr,
   output logic [31:0]                    o_pc_id,
   output logic [31:0]                    o_pc_plus4_id,
   output logic                           o_instr_valid,
   output logic                           o_fetch_error
);

   localparam int          AW     = $clog2(profundidad);
   localparam logic [32:0] LIMITE = 33'(profundidad) << 2;

   typedef enum logic [1:0] {
      ARRANQUE,
      RUN,
      HALT
   } estado_t;

   // An address is fetchable only when word-aligned and inside the ROM.
   function automatic logic esLegal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ({1'b0, a} < LIMITE);
   endfunction

   estado_t     r_estado;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pcId;
   logic [31:0] r_pcPlus4Id;
   logic        r_instrValid;
   logic        r_fetchError;

   logic [31:0] w_pcPlus4;
   logic        w_pcPlus4Legal;
   logic        w_targetLegal;

   assign w_pcPlus4      = r_pc + 32'd4;
   assign w_pcPlus4Legal = esLegal(w_pcPlus4);
   assign w_targetLegal  = esLegal(i_branch_target);

   // The ROM address depends only on the PC register, never on stall/branch.
   assign o_rom_address = r_pc[AW+1:2];
   assign o_instr       = r_instr;
   assign o_pc_id       = r_pcId;
   assign o_pc_plus4_id = r_pcPlus4Id;
   assign o_instr_valid = r_instrValid;
   assign o_fetch_error = r_fetchError;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_estado     <= ARRANQUE;
         r_pc         <= PC_RESET;
         r_instr      <= NOP;
         r_pcId       <= 32'd0;
         r_pcPlus4Id  <= 32'd0;
         r_instrValid <= 1'b0;
         r_fetchError <= 1'b0;
      end else begin
         case (r_estado)
            ARRANQUE: begin
               if (esLegal(PC_RESET)) begin
                  r_estado <= RUN;
               end else begin
                  r_estado     <= HALT;
                  r_fetchError <= 1'b1;
               end
            end
            RUN: begin
               // A redirect beats a stall; the word fetched this cycle is squashed.
               if (i_branch_taken) begin
                  r_instr      <= NOP;
                  r_instrValid <= 1'b0;
                  if (w_targetLegal) begin
                     r_pc <= i_branch_target;
                  end else begin
                     r_estado     <= HALT;
                     r_fetchError <= 1'b1;
                  end
               end else if (!i_stall) begin
                  r_instr      <= i_rom_data;
                  r_pcId       <= r_pc;
                  r_pcPlus4Id  <= w_pcPlus4;
                  r_instrValid <= 1'b1;
                  if (w_pcPlus4Legal) begin
                     r_pc <= w_pcPlus4;
                  end else begin
                     r_estado     <= HALT;
                     r_fetchError <= 1'b1;
                  end
               end
            end
            HALT: begin
               r_instr      <= NOP;
               r_instrValid <= 1'b0;
               r_fetchError <= 1'b1;
            end
            default: begin
               r_estado <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural fetch model and against literal values.
module tb_fetch_control;

   localparam int          DEPTH = 1024;
   localparam int          AW    = 10;
   localparam logic [31:0] NOPI  = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          reset, stall, branchTaken;
   logic [31:0]   branchTarget;
   logic [AW-1:0] romAddr;
   logic [31:0]   romData;
   logic [31:0]   instr, pcId, pcPlus4Id;
   logic          instrValid, fetchError;

   int total = 0;
   int bad   = 0;

   fetch_control #(.profundidad(DEPTH)) dut (
      .i_clk(clk),
      .i_reset(reset),
      .i_stall(stall),
      .i_branch_taken(branchTaken),
      .i_branch_target(branchTarget),
      .o_rom_address(romAddr),
      .i_rom_data(romData),
      .o_instr(instr),
      .o_pc_id(pcId),
      .o_pc_plus4_id(pcPlus4Id),
      .o_instr_valid(instrValid),
      .o_fetch_error(fetchError)
   );

   always #5 clk = ~clk;

   // ROM contents: word k holds 0x1000_0000 + k.
   function automatic logic [31:0] romWord(input logic [31:0] byteAddr);
      return 32'h1000_0000 + {22'd0, byteAddr[AW+1:2]};
   endfunction

   assign romData = 32'h1000_0000 + {22'd0, romAddr};

   // Behavioural model state
   logic [31:0] mPc, mInstr, mPcId, mPc4;
   logic        mValid, mErr, mHalted, mStarting;
   logic        modelReady = 1'b0;

   function automatic logic legal(input logic [31:0] a);
      return (a % 4 == 0) && (longint'(a) < 4 * DEPTH);
   endfunction

   task automatic modelStep(input logic r, input logic s, input logic b, input logic [31:0] t);
      if (r) begin
         mPc = 32'h0; mInstr = NOPI; mPcId = 0; mPc4 = 0;
         mValid = 0; mErr = 0; mHalted = 0; mStarting = 1;
         modelReady = 1'b1;
      end else if (!modelReady) begin
         // nothing known before the first reset
      end else if (mStarting) begin
         mStarting = 0;
      end else if (mHalted) begin
         mInstr = NOPI; mValid = 0;
      end else if (b) begin
         mInstr = NOPI; mValid = 0;
         if (legal(t)) mPc = t;
         else begin mHalted = 1; mErr = 1; end
      end else if (!s) begin
         mInstr = romWord(mPc); mPcId = mPc; mPc4 = mPc + 4; mValid = 1;
         if (legal(mPc + 4)) mPc = mPc + 4;
         else begin mHalted = 1; mErr = 1; end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [31:0] t);
      reset = r; stall = s; branchTaken = b; branchTarget = t;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, settle.
   task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
      applyStimulus(r, s, b, t);
      @(posedge clk);
      modelStep(r, s, b, t);
      #1;
   endtask

   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("m_instr", instr, mInstr);
         checkOutput("m_pc_id", pcId, mPcId);
         checkOutput("m_pc4", pcPlus4Id, mPc4);
         checkOutput("m_valid", 32'(instrValid), 32'(mValid));
         checkOutput("m_err", 32'(fetchError), 32'(mErr));
         checkOutput("m_romaddr", 32'(romAddr), 32'(mPc[AW+1:2]));
      end
   end

   initial begin
      logic [AW-1:0] heldAddr;
      logic          found;
      logic [31:0]   tgt;
      applyStimulus(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      checkOutput("rst_valid", 32'(instrValid), 0);
      checkOutput("rst_instr", instr, NOPI);
      checkOutput("rst_addr", 32'(romAddr), 0);

      // Free run from reset
      cycle(0, 0, 0, 0);
      checkOutput("e1_valid", 32'(instrValid), 0);
      checkOutput("e1_instr", instr, NOPI);
      cycle(0, 0, 0, 0);
      checkOutput("e2_instr", instr, 32'h1000_0000);
      checkOutput("e2_pcid", pcId, 0);
      checkOutput("e2_valid", 32'(instrValid), 1);
      cycle(0, 0, 0, 0);
      checkOutput("e3_instr", instr, 32'h1000_0001);
      checkOutput("e3_pcid", pcId, 4);
      checkOutput("e3_pc4", pcPlus4Id, 8);
      cycle(0, 0, 0, 0);
      checkOutput("e4_pcid", pcId, 8);

      // Stall three cycles with pc_id = 8
      heldAddr = romAddr;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0);
         checkOutput("stall_pcid", pcId, 8);
         checkOutput("stall_instr", instr, 32'h1000_0002);
         checkOutput("stall_addr", 32'(romAddr), 32'(heldAddr));
      end
      cycle(0, 0, 0, 0);
      checkOutput("rel_pcid", pcId, 12);
      checkOutput("rel_instr", instr, 32'h1000_0003);

      // Redirect to 0x40 with stall also asserted, pc = 16
      cycle(0, 1, 1, 32'h40);
      checkOutput("br_valid", 32'(instrValid), 0);
      checkOutput("br_instr", instr, NOPI);
      cycle(0, 0, 0, 0);
      checkOutput("br_tinstr", instr, 32'h1000_0010);
      checkOutput("br_tpcid", pcId, 32'h40);

      // Misaligned target halts
      cycle(0, 0, 1, 32'h42);
      checkOutput("mis_err", 32'(fetchError), 1);
      checkOutput("mis_valid", 32'(instrValid), 0);
      heldAddr = romAddr;
      for (int i = 0; i < 4; i++) begin
         cycle(0, i[0], 1, 32'h100);
         checkOutput("halt_err", 32'(fetchError), 1);
         checkOutput("halt_valid", 32'(instrValid), 0);
         checkOutput("halt_addr", 32'(romAddr), 32'(heldAddr));
      end
      cycle(1, 0, 0, 0);
      checkOutput("clr_err", 32'(fetchError), 0);

      // Out-of-range target halts
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 32'h1000);
      checkOutput("oor_err", 32'(fetchError), 1);
      checkOutput("oor_valid", 32'(instrValid), 0);
      cycle(1, 0, 0, 0);
      checkOutput("oor_clr", 32'(fetchError), 0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 63) == 0) tgt = $urandom;
         else tgt = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
         cycle($urandom_range(0, 63) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0,
               tgt);
      end

      // Walk off the end of the ROM
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 32'hFF0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(0, 0, 0, 0);
         if (pcId == 32'hFFC && instrValid) found = 1'b1;
      end
      checkOutput("eor_reached", 32'(found), 1);
      checkOutput("eor_instr", instr, 32'h1000_03FF);
      checkOutput("eor_valid", 32'(instrValid), 1);
      cycle(0, 1, 1, 32'h40);
      checkOutput("eor_nvalid", 32'(instrValid), 0);
      checkOutput("eor_err", 32'(fetchError), 1);
      checkOutput("eor_addr", 32'(romAddr), 1023);

      // Reset on the same edge as a redirect
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(1, 0, 1, 32'h80);
      checkOutput("rr_addr", 32'(romAddr), 0);
      checkOutput("rr_valid", 32'(instrValid), 0);
      checkOutput("rr_instr", instr, NOPI);
      checkOutput("rr_pcid", pcId, 0);
      cycle(0, 0, 0, 0);
      checkOutput("rr_arr_valid", 32'(instrValid), 0);
      checkOutput("rr_arr_addr", 32'(romAddr), 0);
      cycle(0, 0, 0, 0);
      checkOutput("rr_instr0", instr, 32'h1000_0000);
      checkOutput("rr_pcid0", pcId, 0);
      checkOutput("rr_valid0", 32'(instrValid), 1);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_control.md
Name: fetch_control

Overview:
- Instruction-fetch sequencer for the single-cycle-read instruction ROM: owns the program counter, drives the ROM word address, and registers the fetched word into the IF/ID stage.
- Handles hazard stalls, branch/jump redirects with squash of the wrong-path instruction, and a halt on an illegal fetch address.
- Sits between the instruction ROM and the decode stage of the core.

Parameters:
- profundidad, 1024: ROM depth in 32-bit words. Word address width AW = $clog2(profundidad), 10 at default.
- PC_RESET, 32'h00000000: byte address of the first fetch after reset.
- NOP, 32'h00000013: bubble instruction driven on squash, halt and reset (addi x0,x0,0).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit request to hold PC and the IF/ID register.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  32  byte address of the redirect.
- rom_address  out  AW  ROM word address, equal to pc[AW+1:2]; combinational from the PC register.
- rom_data  in  32  ROM read data; combinational, valid in the same cycle as rom_address.
- instr  out  32  registered instruction to decode.
- pc_id  out  32  registered byte PC of instr.
- pc_plus4_id  out  32  pc_id + 4, registered.
- instr_valid  out  1  instr is a real instruction, not a bubble.
- fetch_error  out  1  sticky; set on an illegal fetch address.

Behaviour:
- Internal pc register is 32 bits. Additions are modulo 2^32; pc is legal when pc[1:0]==0 and pc < 4*profundidad.
- States: ARRANQUE, RUN, HALT.
- Reset (any state, any cycle, including mid-stall or mid-redirect), on the next edge:
  - pc=PC_RESET, instr=NOP, pc_id=0, pc_plus4_id=0, instr_valid=0, fetch_error=0, state=ARRANQUE.
- ARRANQUE: lasts exactly one cycle.
  - Outputs hold their reset values and pc does not advance.
  - Inputs are ignored; next state is RUN.
  - If PC_RESET is illegal, next state is HALT with fetch_error=1 instead.
- RUN, priority order each edge:
  1. branch_taken=1 (overrides stall):
     - If branch_target is legal: pc<=branch_target, instr<=NOP, instr_valid<=0, pc_id and pc_plus4_id hold. The instruction fetched this cycle is discarded.
     - If branch_target is illegal: state<=HALT, fetch_error<=1, instr<=NOP, instr_valid<=0.
  2. stall=1: pc, instr, pc_id, pc_plus4_id and instr_valid all hold.
  3. Otherwise (normal fetch):
     - instr<=rom_data, pc_id<=pc, pc_plus4_id<=pc+4, instr_valid<=1.
     - If pc+4 is legal, pc<=pc+4.
     - If pc+4 is illegal (walked off the ROM end): the current word is still delivered, pc holds, state<=HALT, fetch_error<=1.
- Fetch latency: address presented in cycle N appears on instr/instr_valid after edge N+1.
- Redirect penalty: exactly one bubble. The target instruction is valid after the second edge following the branch_taken edge, provided there is no stall.
- HALT:
  - instr=NOP, instr_valid=0 from the first HALT cycle onward; the one exception is the end-of-ROM case, whose last word is delivered on the transition edge.
  - pc frozen, fetch_error=1, all inputs ignored; exit only through reset.
- rom_address always reflects the current pc, including in HALT.
- No combinational path from stall or branch_taken to rom_address.

Test Plan:
- Reset then run free, ROM word k = 32'h1000_0000+k:
  - Edge 1 after reset: valid=0.
  - Edge 2: instr=32'h1000_0000, pc_id=0, valid=1.
  - Edge 3: instr=32'h1000_0001, pc_id=4, pc_plus4_id=8.
- Stall held 3 cycles while pc_id=8:
  - instr, pc_id and rom_address stay constant for 3 cycles.
  - After release the next instr has pc_id=12, with no skipped or duplicated word.
- branch_taken with branch_target=32'h40 while pc=16, stall also asserted:
  - Next edge gives valid=0 and instr=NOP.
  - Following edge gives instr=word 16, pc_id=32'h40.
- branch_target=32'h42 (misaligned), then a separate run with target 32'h1000 (beyond 4*1024):
  - Both set fetch_error=1 and valid=0 and enter HALT.
  - Further stall/branch inputs are ignored.
  - Reset clears fetch_error.
- Sequential run to pc=32'hFFC:
  - Word 1023 is delivered with valid=1.
  - The next cycle has valid=0, fetch_error=1, and rom_address holds 1023.
- Reset asserted for one cycle mid-redirect (branch_taken=1 on the same edge):
  - Reset wins: pc=PC_RESET, outputs at reset values, one ARRANQUE cycle.
  - Fetch then resumes from 0.
